traffic_cmd_arbiter: RTL and testbench

TRAFFIC_CMD_ARBITER -- requirements
Module: traffic_cmd_arbiter

---
 rtl/traffic_cmd_arbiter_if.sv | 34 +++
 rtl/traffic_cmd_arbiter.sv | 155 +++++++++++++++
 tb/tb_traffic_cmd_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/traffic_cmd_arbiter_if.sv
// rtl/traffic_cmd_arbiter_if.sv - command type package and requester/command bus interface
package traffic_cmd_pkg;
  typedef enum logic [2:0] {
    SET_OFF    = 3'd0,
    SET_ON     = 3'd1,
    SET_RED    = 3'd2,
    SET_YELLOW = 3'd3,
    SET_GREEN  = 3'd4
  } command_e;
endpackage

interface traffic_cmd_arbiter_if #(
  parameter int REQ_NUM = 2
);
  logic [REQ_NUM-1:0]                       req_valid_i;
  traffic_cmd_pkg::command_e [REQ_NUM-1:0]  req_type_i;
  logic [REQ_NUM-1:0][15:0]                 req_data_i;
  logic [REQ_NUM-1:0]                       req_ready_o;
  traffic_cmd_pkg::command_e                cmd_type_o;
  logic                                     cmd_valid_o;
  logic [15:0]                              cmd_data_o;
  logic                                     boot_done_o;
  logic                                     err_zero_o;

  modport master (
    output req_valid_i, req_type_i, req_data_i,
    input  req_ready_o, cmd_type_o, cmd_valid_o, cmd_data_o, boot_done_o, err_zero_o
  );

  modport slave (
    input  req_valid_i, req_type_i, req_data_i,
    output req_ready_o, cmd_type_o, cmd_valid_o, cmd_data_o, boot_done_o, err_zero_o
  );
endinterface

// File: rtl/traffic_cmd_arbiter.sv
// rtl/traffic_cmd_arbiter.sv - round-robin command arbiter feeding a traffic light controller
// Define TRAFFIC_ARB_BOOT_EN to issue the default RED/YELLOW/GREEN/ON sequence after reset.
module traffic_cmd_arbiter
  import traffic_cmd_pkg::*;
#(
  parameter int REQ_NUM       = 2,
  parameter int GAP_CYCLES    = 1,
  parameter int DEF_RED_MS    = 10,
  parameter int DEF_YELLOW_MS = 3,
  parameter int DEF_GREEN_MS  = 8
) (
  input  logic                  clk_2k_i,
  input  logic                  srst_i,
  traffic_cmd_arbiter_if.slave  bus
);

`ifdef TRAFFIC_ARB_BOOT_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif

  localparam int              PTR_W      = (REQ_NUM > 2) ? 2 : 1;
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(REQ_NUM - 1);
  localparam logic [3:0]      GAP_LOAD   = 4'(GAP_CYCLES - 1);
  localparam logic [2:0]      BOOT_STEPS = 3'd4;

  typedef enum logic [1:0] {ST_BOOT, ST_IDLE, ST_GAP} state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic [2:0]       boot_idx_q, boot_idx_d;
  logic             cmd_valid_q, cmd_valid_d;
  command_e         cmd_type_q, cmd_type_d;
  logic [15:0]      cmd_data_q, cmd_data_d;
  logic             err_zero_q, err_zero_d;
  logic             boot_done_q, boot_done_d;

  logic             grant_any;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] cand_idx;
  int               cand;
  logic [REQ_NUM-1:0] ready;
  command_e         grant_type;
  logic [15:0]      grant_data;
  logic             zero_timing;

  // First valid requester at or after rr_ptr, wrapping modulo REQ_NUM.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= REQ_NUM) cand = cand - REQ_NUM;
      cand_idx = cand[PTR_W-1:0];
      if (!grant_any && bus.req_valid_i[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin
    ready = '0;
    if (state_q == ST_IDLE && grant_any && !srst_i) ready[grant_idx] = 1'b1;
    grant_type  = bus.req_type_i[grant_idx];
    grant_data  = bus.req_data_i[grant_idx];
    zero_timing = (grant_type inside {SET_RED, SET_YELLOW, SET_GREEN}) && (grant_data == 16'd0);
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gap_cnt_d   = gap_cnt_q;
    boot_idx_d  = boot_idx_q;
    cmd_valid_d = 1'b0;
    cmd_type_d  = cmd_type_q;
    cmd_data_d  = cmd_data_q;
    err_zero_d  = err_zero_q;
    case (state_q)
      ST_BOOT: begin
        cmd_valid_d = 1'b1;
        case (boot_idx_q)
          3'd0:    begin cmd_type_d = SET_RED;    cmd_data_d = 16'(DEF_RED_MS);    end
          3'd1:    begin cmd_type_d = SET_YELLOW; cmd_data_d = 16'(DEF_YELLOW_MS); end
          3'd2:    begin cmd_type_d = SET_GREEN;  cmd_data_d = 16'(DEF_GREEN_MS);  end
          default: begin cmd_type_d = SET_ON;     cmd_data_d = 16'd0;              end
        endcase
        boot_idx_d = boot_idx_q + 3'd1;
        gap_cnt_d  = GAP_LOAD;
        state_d    = ST_GAP;
      end
      ST_IDLE: begin
        if (|ready) begin
          rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
          // Zero-length phases are swallowed: flag it and stay ready for the next requester.
          if (zero_timing) begin
            err_zero_d = 1'b1;
          end else begin
            cmd_valid_d = 1'b1;
            cmd_type_d  = grant_type;
            cmd_data_d  = grant_data;
            gap_cnt_d   = GAP_LOAD;
            state_d     = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = (BOOT_EN && boot_idx_q != BOOT_STEPS) ? ST_BOOT : ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    boot_done_d = boot_done_q | (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_2k_i) begin
    if (srst_i) begin
      if (BOOT_EN) state_q <= ST_BOOT;
      else         state_q <= ST_IDLE;
      rr_ptr_q    <= '0;
      gap_cnt_q   <= 4'd0;
      boot_idx_q  <= 3'd0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= SET_OFF;
      cmd_data_q  <= 16'd0;
      err_zero_q  <= 1'b0;
      boot_done_q <= ~BOOT_EN;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gap_cnt_q   <= gap_cnt_d;
      boot_idx_q  <= boot_idx_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_data_q  <= cmd_data_d;
      err_zero_q  <= err_zero_d;
      boot_done_q <= boot_done_d;
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.cmd_valid_o = cmd_valid_q;
  assign bus.cmd_type_o  = cmd_type_q;
  assign bus.cmd_data_o  = cmd_data_q;
  assign bus.err_zero_o  = err_zero_q;
  assign bus.boot_done_o = boot_done_q;

endmodule

// File: tb/tb_traffic_cmd_arbiter.sv
// tb/tb_traffic_cmd_arbiter.sv - directed bench for traffic_cmd_arbiter (3 req/gap 1 and 2 req/gap 3)
module tb_traffic_cmd_arbiter;
  import traffic_cmd_pkg::*;

  logic clk = 1'b0;
  logic srst;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  traffic_cmd_arbiter_if #(.REQ_NUM(3)) bus_a ();
  traffic_cmd_arbiter_if #(.REQ_NUM(2)) bus_b ();

  traffic_cmd_arbiter #(.REQ_NUM(3), .GAP_CYCLES(1)) u_dut_a (
    .clk_2k_i (clk),
    .srst_i   (srst),
    .bus      (bus_a.slave)
  );

  traffic_cmd_arbiter #(.REQ_NUM(2), .GAP_CYCLES(3)) u_dut_b (
    .clk_2k_i (clk),
    .srst_i   (srst),
    .bus      (bus_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input int n, input logic v, input command_e t, input logic [15:0] d);
    bus_a.req_valid_i[n] = v;
    bus_a.req_type_i[n]  = t;
    bus_a.req_data_i[n]  = d;
  endtask

  task automatic set_b(input int n, input logic v, input command_e t, input logic [15:0] d);
    bus_b.req_valid_i[n] = v;
    bus_b.req_type_i[n]  = t;
    bus_b.req_data_i[n]  = d;
  endtask

`ifdef TRAFFIC_ARB_BOOT_EN
  task automatic boot_check(input int upto);
    command_e exp_t [4];
    int       exp_d [4];
    exp_t = '{SET_RED, SET_YELLOW, SET_GREEN, SET_ON};
    exp_d = '{10, 3, 8, 0};
    for (int k = 1; k <= upto; k++) begin
      @(negedge clk); #1;
      check($sformatf("boot_valid_%0d", k), 32'(bus_a.cmd_valid_o), 32'(k % 2));
      if (k % 2 == 1) begin
        check($sformatf("boot_type_%0d", k), 32'(bus_a.cmd_type_o), 32'(exp_t[(k - 1) / 2]));
        check($sformatf("boot_data_%0d", k), 32'(bus_a.cmd_data_o), 32'(exp_d[(k - 1) / 2]));
      end
      check($sformatf("boot_done_%0d", k), 32'(bus_a.boot_done_o), 32'(k >= 8));
    end
  endtask
`endif

  initial begin
    int       alt_ready [8];
    int       alt_data  [8];
    command_e alt_type  [8];
    alt_ready = '{1, 0, 2, 0, 1, 0, 2, 0};
    alt_data  = '{7, 100, 100, 200, 200, 100, 100, 200};
    alt_type  = '{SET_OFF, SET_RED, SET_OFF, SET_GREEN, SET_OFF, SET_RED, SET_OFF, SET_GREEN};

    srst = 1'b1;
    for (int n = 0; n < 3; n++) set_a(n, 1'b0, SET_OFF, 16'd0);
    for (int n = 0; n < 2; n++) set_b(n, 1'b0, SET_OFF, 16'd0);
    repeat (2) @(negedge clk);

    // Reset values, with every requester valid so ready gating is exercised.
    for (int n = 0; n < 3; n++) set_a(n, 1'b1, SET_OFF, 16'd0);
    for (int n = 0; n < 2; n++) set_b(n, 1'b1, SET_OFF, 16'd0);
    #1;
    check("rst_ready_a", 32'(bus_a.req_ready_o), 32'd0);
    check("rst_ready_b", 32'(bus_b.req_ready_o), 32'd0);
    check("rst_valid",   32'(bus_a.cmd_valid_o), 32'd0);
    check("rst_data",    32'(bus_a.cmd_data_o),  32'd0);
    check("rst_type",    32'(bus_a.cmd_type_o),  32'(SET_OFF));
    check("rst_err",     32'(bus_a.err_zero_o),  32'd0);
    for (int n = 0; n < 3; n++) set_a(n, 1'b0, SET_OFF, 16'd0);
    for (int n = 0; n < 2; n++) set_b(n, 1'b0, SET_OFF, 16'd0);

    @(negedge clk);
    srst = 1'b0;

`ifdef TRAFFIC_ARB_BOOT_EN
    // Reset lands on the SET_YELLOW strobe; boot must restart from SET_RED.
    boot_check(3);
    srst = 1'b1;
    @(negedge clk); #1;
    check("midrst_valid", 32'(bus_a.cmd_valid_o), 32'd0);
    check("midrst_type",  32'(bus_a.cmd_type_o),  32'(SET_OFF));
    check("midrst_data",  32'(bus_a.cmd_data_o),  32'd0);
    check("midrst_done",  32'(bus_a.boot_done_o), 32'd0);
    srst = 1'b0;
    boot_check(8);
    for (int k = 9; k <= 16; k++) begin
      @(negedge clk); #1;
      if (k == 13) begin
        check("boot_b_on_valid", 32'(bus_b.cmd_valid_o), 32'd1);
        check("boot_b_on_type",  32'(bus_b.cmd_type_o),  32'(SET_ON));
      end
      if (k >= 15) check($sformatf("boot_b_done_%0d", k), 32'(bus_b.boot_done_o), 32'(k == 16));
    end
`else
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      check($sformatf("noboot_done_a_%0d", k), 32'(bus_a.boot_done_o), 32'd1);
      check($sformatf("noboot_done_b_%0d", k), 32'(bus_b.boot_done_o), 32'd1);
      check($sformatf("noboot_valid_%0d", k),  32'(bus_a.cmd_valid_o), 32'd0);
    end
`endif

    // Only requester 2 valid with rr_ptr at 0: immediate grant, pointer wraps to 0.
    @(negedge clk);
    set_a(2, 1'b1, SET_YELLOW, 16'd7);
    #1;
    check("wrap_ready", 32'(bus_a.req_ready_o), 32'b100);
    @(negedge clk);
    set_a(2, 1'b0, SET_OFF, 16'd0);
    #1;
    check("wrap_valid", 32'(bus_a.cmd_valid_o), 32'd1);
    check("wrap_type",  32'(bus_a.cmd_type_o),  32'(SET_YELLOW));
    check("wrap_data",  32'(bus_a.cmd_data_o),  32'd7);
    check("wrap_gap",   32'(bus_a.req_ready_o), 32'd0);

    // Two requesters held valid: grants alternate starting at 0.
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j == 0) begin
        set_a(0, 1'b1, SET_RED,   16'd100);
        set_a(1, 1'b1, SET_GREEN, 16'd200);
      end
      #1;
      check($sformatf("alt_ready_%0d", j), 32'(bus_a.req_ready_o), 32'(alt_ready[j]));
      check($sformatf("alt_valid_%0d", j), 32'(bus_a.cmd_valid_o), 32'(j % 2));
      check($sformatf("alt_data_%0d", j),  32'(bus_a.cmd_data_o),  32'(alt_data[j]));
      if (j % 2 == 1) check($sformatf("alt_type_%0d", j), 32'(bus_a.cmd_type_o), 32'(alt_type[j]));
    end

    // Withdrawn before grant: nothing issued.
    @(negedge clk);
    set_a(0, 1'b0, SET_OFF, 16'd0);
    set_a(1, 1'b0, SET_OFF, 16'd0);
    #1;
    check("drop_ready", 32'(bus_a.req_ready_o), 32'd0);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk); #1;
      check($sformatf("drop_valid_%0d", j), 32'(bus_a.cmd_valid_o), 32'd0);
    end

    // Zero-duration SET_GREEN from requester 1: accepted, dropped, flagged, no gap.
    @(negedge clk);
    set_a(1, 1'b1, SET_GREEN, 16'd0);
    #1;
    check("zero_ready",   32'(bus_a.req_ready_o), 32'b010);
    check("zero_err_pre", 32'(bus_a.err_zero_o),  32'd0);
    @(negedge clk);
    set_a(1, 1'b0, SET_OFF, 16'd0);
    set_a(0, 1'b1, SET_ON, 16'd1);
    #1;
    check("zero_no_valid", 32'(bus_a.cmd_valid_o), 32'd0);
    check("zero_err",      32'(bus_a.err_zero_o),  32'd1);
    check("zero_no_gap",   32'(bus_a.req_ready_o), 32'b001);
    check("zero_hold",     32'(bus_a.cmd_data_o),  32'd200);
    @(negedge clk);
    set_a(0, 1'b0, SET_OFF, 16'd0);
    #1;
    check("after_zero_valid", 32'(bus_a.cmd_valid_o), 32'd1);
    check("after_zero_data",  32'(bus_a.cmd_data_o),  32'd1);
    check("err_sticky",       32'(bus_a.err_zero_o),  32'd1);

    // GAP_CYCLES=3 with requester 0 always valid: a strobe every 4 cycles.
    for (int j = 0; j <= 12; j++) begin
      @(negedge clk);
      if (j == 0) set_b(0, 1'b1, SET_ON, 16'd5);
      #1;
      check($sformatf("gap3_ready_%0d", j), 32'(bus_b.req_ready_o), 32'(j % 4 == 0));
      check($sformatf("gap3_valid_%0d", j), 32'(bus_b.cmd_valid_o), 32'(j % 4 == 1));
    end
    @(negedge clk);
    set_b(0, 1'b0, SET_OFF, 16'd0);

    // Reset clears the sticky flag and the pending strobe state.
    srst = 1'b1;
    @(negedge clk); #1;
    check("final_err",    32'(bus_a.err_zero_o),  32'd0);
    check("final_valid",  32'(bus_b.cmd_valid_o), 32'd0);
    check("final_data_b", 32'(bus_b.cmd_data_o),  32'd0);
    srst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
